// File: rtl/fsm_peripheral_rx_fifo_if.sv
// Controller-to-peripheral handshake plus local FIFO drain bus.
// master = controller/drain side, slave = the receiver peripheral.
interface fsm_peripheral_rx_fifo_if #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic              SEND_per;
  logic [DATA_W-1:0] inputData_per;
  logic              outACK_per;
  logic              rd_en_per;
  logic [DATA_W-1:0] rd_data_per;
  logic              rd_valid_per;
  logic              full_per;
  logic [CW-1:0]     count_per;

  modport master (
    output SEND_per, inputData_per, rd_en_per,
    input  outACK_per, rd_data_per, rd_valid_per, full_per, count_per
  );

  modport slave (
    input  SEND_per, inputData_per, rd_en_per,
    output outACK_per, rd_data_per, rd_valid_per, full_per, count_per
  );
endinterface

// File: rtl/fsm_peripheral_rx_fifo.sv
// Four-phase SEND/ACK receiver into a DEPTH-word FWFT FIFO; ACK rises SYNC_STAGES+1 cycles after SEND.
// Back-pressure: ACK is withheld while the FIFO is full; one word is taken per handshake.
module fsm_peripheral_rx_fifo #(
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_per,
  input  logic rst_per,
  fsm_peripheral_rx_fifo_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    WAIT_LOW = 2'd0,
    IDLE     = 2'd1,
    ACK      = 2'd2
  } state_t;

  state_t            state_q;
  logic              ack_q;
  logic              send_s;
  logic [PW-1:0]     wr_ptr_q;
  logic [PW-1:0]     rd_ptr_q;
  logic [CW-1:0]     count_q;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              full;
  logic              wr_en;
  logic              rd_en;

  // Sync flops reset to 1 so a request held across reset looks stale, not new.
  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign send_s = bus.SEND_per;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] sync_q;
      always_ff @(posedge clk_per) begin
        if (rst_per) begin
          sync_q <= '1;
        end else begin
          sync_q[0] <= bus.SEND_per;
          for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
          end
        end
      end
      assign send_s = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  assign full  = (count_q == CW'(DEPTH));
  assign wr_en = (state_q == IDLE) && send_s && !full;
  assign rd_en = bus.rd_en_per && (count_q != '0);

  always_ff @(posedge clk_per) begin
    if (rst_per) begin
      state_q <= WAIT_LOW;
      ack_q   <= 1'b0;
    end else begin
      case (state_q)
        WAIT_LOW: begin
          ack_q <= 1'b0;
          if (!send_s) state_q <= IDLE;
        end
        IDLE: begin
          if (wr_en) begin
            state_q <= ACK;
            ack_q   <= 1'b1;
          end else begin
            ack_q   <= 1'b0;
          end
        end
        ACK: begin
          if (!send_s) begin
            state_q <= IDLE;
            ack_q   <= 1'b0;
          end else begin
            ack_q   <= 1'b1;
          end
        end
        default: begin
          state_q <= WAIT_LOW;
          ack_q   <= 1'b0;
        end
      endcase
    end
  end

  // Storage has no reset: contents are invisible until count_q says otherwise.
  always_ff @(posedge clk_per) begin
    if (wr_en) mem[wr_ptr_q] <= bus.inputData_per;
  end

  always_ff @(posedge clk_per) begin
    if (rst_per) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (rd_en) rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({wr_en, rd_en})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign bus.outACK_per   = ack_q;
  assign bus.rd_data_per  = mem[rd_ptr_q];
  assign bus.rd_valid_per = (count_q != '0);
  assign bus.full_per     = full;
  assign bus.count_per    = count_q;
endmodule
